// File: rtl/micro_hash_pkg.sv
// Shared definitions for the 24-bit micro-hash: initial hash bytes, round
// constants, controller state encoding and the message-schedule helpers.
package micro_hash_pkg;

    typedef logic [7:0]       byte_t;
    typedef logic [15:0][7:0] window_t;   // element 0 is the oldest byte W[i]

    localparam byte_t H_INIT_A    = 8'h01;
    localparam byte_t H_INIT_B    = 8'h89;
    localparam byte_t H_INIT_C    = 8'hFE;
    localparam byte_t K_LO        = 8'h99;
    localparam byte_t K_HI        = 8'hA1;
    localparam int    ROUNDS      = 32;
    localparam int    SPLIT_ROUND = 16;

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        FINAL,
        DONE
    } state_t;

    // Byte order: payload[95:88] is W0, nonce[7:0] is W15.
    function automatic window_t load_window(input logic [95:0] payload,
                                            input logic [31:0] nonce);
        window_t w;
        for (int k = 0; k < 12; k++) w[k]      = payload[95-8*k -: 8];
        for (int k = 0; k < 4;  k++) w[12 + k] = nonce[31-8*k -: 8];
        return w;
    endfunction

    // W[i+16] = W[i+13] | (W[i+7] ^ W[i+2]), taken from the current window.
    function automatic byte_t sched_next(input byte_t w13, input byte_t w7,
                                         input byte_t w2);
        return w13 | (w7 ^ w2);
    endfunction

endpackage

// File: rtl/micro_hash_round.sv
// One combinational micro-hash round; chained UNROLL times by the verifier
// and reused unchanged by the miner.
module micro_hash_round
    import micro_hash_pkg::*;
(
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    input  logic [7:0] i_c,
    input  logic [7:0] i_w,
    input  logic [5:0] i_round,
    output logic [7:0] o_a,
    output logic [7:0] o_b,
    output logic [7:0] o_c
);

    logic       w_late;
    logic [7:0] w_x;
    logic [7:0] w_k;

    // Rounds 0..16 inclusive use the low constant and leave c out of x.
    assign w_late = (i_round > 6'(SPLIT_ROUND));
    assign w_x    = w_late ? (i_a ^ i_b ^ i_c) : (i_a ^ i_b);
    assign w_k    = w_late ? K_HI : K_LO;

    assign o_a = i_b ^ i_c;
    assign o_b = {i_c[3:0], 4'h0};
    assign o_c = w_x + w_k + i_w;

endmodule

// File: rtl/micro_hash_verify.sv
// Recomputes the micro-hash of a reported solution and flags whether it
// matches the reported hash and whether it meets the difficulty target.
module micro_hash_verify
    import micro_hash_pkg::*;
#(
    parameter int UNROLL = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [95:0] payload,
    input  logic [31:0] nonce,
    input  logic [7:0]  target,
    input  logic [23:0] hash_in,
    output logic        ready,
    output logic        done,
    output logic        match,
    output logic        meets,
    output logic [23:0] hash_calc
);

    if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4) begin : g_bad_unroll
        $error("micro_hash_verify: UNROLL must be 1, 2 or 4");
    end

    state_t      r_state;
    logic        r_ready;
    logic        r_done;
    logic        r_match;
    logic        r_meets;
    logic [23:0] r_hash;
    logic [5:0]  r_idx;
    logic [7:0]  r_target;
    logic [23:0] r_hash_in;
    window_t     r_win;
    byte_t       r_a;
    byte_t       r_b;
    byte_t       r_c;

    byte_t       w_a   [UNROLL+1];
    byte_t       w_b   [UNROLL+1];
    byte_t       w_c   [UNROLL+1];
    window_t     w_win [UNROLL+1];
    logic [23:0] w_hash;

    assign w_a[0]   = r_a;
    assign w_b[0]   = r_b;
    assign w_c[0]   = r_c;
    assign w_win[0] = r_win;

    // Each stage consumes window byte 0 and appends the next scheduled byte.
    for (genvar j = 0; j < UNROLL; j++) begin : g_round
        micro_hash_round u_round (
            .i_a     (w_a[j]),
            .i_b     (w_b[j]),
            .i_c     (w_c[j]),
            .i_w     (w_win[j][0]),
            .i_round (r_idx + 6'(j)),
            .o_a     (w_a[j+1]),
            .o_b     (w_b[j+1]),
            .o_c     (w_c[j+1])
        );
        assign w_win[j+1] = {sched_next(w_win[j][13], w_win[j][7], w_win[j][2]),
                             w_win[j][15:1]};
    end

    assign w_hash = {H_INIT_A + r_a, H_INIT_B + r_b, H_INIT_C + r_c};

    // NOTE: datapath registers (window, a/b/c, captured inputs) are not reset;
    // they are always reloaded on start before anything reads them.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_ready <= 1'b1;
            r_done  <= 1'b0;
            r_match <= 1'b0;
            r_meets <= 1'b0;
            r_hash  <= '0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                    if (start) begin
                        r_target  <= target;
                        r_hash_in <= hash_in;
                        r_win     <= load_window(payload, nonce);
                        r_a       <= H_INIT_A;
                        r_b       <= H_INIT_B;
                        r_c       <= H_INIT_C;
                        r_idx     <= '0;
                        r_ready   <= 1'b0;
                        r_state   <= ROUND;
                    end
                end
                ROUND: begin
                    if (r_idx == 6'(ROUNDS)) begin
                        r_state <= FINAL;
                    end else begin
                        r_a   <= w_a[UNROLL];
                        r_b   <= w_b[UNROLL];
                        r_c   <= w_c[UNROLL];
                        r_win <= w_win[UNROLL];
                        r_idx <= r_idx + 6'(UNROLL);
                    end
                end
                FINAL: begin
                    r_hash  <= w_hash;
                    r_match <= (w_hash == r_hash_in);
                    r_meets <= (w_hash[23:16] < r_target) && (w_hash[15:8] < r_target);
                    r_done  <= 1'b1;
                    r_ready <= 1'b1;
                    r_state <= DONE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ready     = r_ready;
    assign done      = r_done;
    assign match     = r_match;
    assign meets     = r_meets;
    assign hash_calc = r_hash;

endmodule

// File: tb/tb_micro_hash_verify.sv
// Randomised bench for micro_hash_verify at UNROLL = 1, 2 and 4 against an
// array-based reference model of the micro-hash.
module tb_micro_hash_verify;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  start_v;
    logic [95:0] payload;
    logic [31:0] nonce;
    logic [7:0]  target;
    logic [23:0] hash_in;
    logic [2:0]  ready_v;
    logic [2:0]  done_v;
    logic [2:0]  match_v;
    logic [2:0]  meets_v;
    logic [23:0] hc_v [3];

    int n_total = 0;
    int n_bad   = 0;

    int          got_lat;
    logic [23:0] got_hash;
    logic        got_match;
    logic        got_meets;
    logic        got_ready;
    logic        got_done_after;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        micro_hash_verify #(.UNROLL(1 << g)) u_dut (
            .clk       (clk),
            .reset     (reset),
            .start     (start_v[g]),
            .payload   (payload),
            .nonce     (nonce),
            .target    (target),
            .hash_in   (hash_in),
            .ready     (ready_v[g]),
            .done      (done_v[g]),
            .match     (match_v[g]),
            .meets     (meets_v[g]),
            .hash_calc (hc_v[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: full 32-entry schedule and plain integer arithmetic.
    function automatic logic [23:0] model_hash(input logic [95:0] p, input logic [31:0] n);
        int w [32];
        int a, b, c, x, k, na, nb, nc;
        for (int i = 0; i < 12; i++) w[i] = int'(p[95-8*i -: 8]);
        for (int i = 0; i < 4; i++)  w[12+i] = int'(n[31-8*i -: 8]);
        for (int i = 16; i < 32; i++) w[i] = w[i-3] | (w[i-9] ^ w[i-14]);
        a = 'h01; b = 'h89; c = 'hFE;
        for (int i = 0; i < 32; i++) begin
            if (i <= 16) begin k = 'h99; x = a ^ b; end
            else         begin k = 'hA1; x = a ^ b ^ c; end
            na = b ^ c;
            nb = (c * 16) % 256;
            nc = (x + k + w[i]) % 256;
            a = na; b = nb; c = nc;
        end
        return {8'((1 + a) % 256), 8'((137 + b) % 256), 8'((254 + c) % 256)};
    endfunction

    function automatic logic model_meets(input logic [23:0] h, input logic [7:0] t);
        return (int'(h[23:16]) < int'(t)) && (int'(h[15:8]) < int'(t));
    endfunction

    task automatic wait_done(input int d, output int lat);
        lat = -1;
        for (int e = 1; e <= 80; e++) begin
            @(posedge clk); #1;
            if (done_v[d]) begin
                lat = e;
                break;
            end
        end
    endtask

    task automatic run_one(input int d, input logic [95:0] p, input logic [31:0] n,
                           input logic [7:0] t, input logic [23:0] h);
        @(negedge clk);
        payload = p; nonce = n; target = t; hash_in = h;
        start_v[d] = 1'b1;
        check($sformatf("d%0d_ready_idle", d), 32'(ready_v[d]), 32'd1);
        @(posedge clk); #1;
        start_v[d] = 1'b0;
        payload = {$urandom, $urandom, $urandom};
        nonce = $urandom; target = 8'($urandom); hash_in = 24'($urandom);
        wait_done(d, got_lat);
        got_hash  = hc_v[d];
        got_match = match_v[d];
        got_meets = meets_v[d];
        got_ready = ready_v[d];
        @(posedge clk); #1;
        got_done_after = done_v[d];
    endtask

    logic [95:0] p, p2;
    logic [31:0] n, n2;
    logic [23:0] exp_h, hin;
    logic [7:0]  tgt, mx;
    int          lat2, dones, tries;

    initial begin
        reset = 1'b1; start_v = '0;
        payload = '0; nonce = '0; target = '0; hash_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("d%0d_rst_ready", d), 32'(ready_v[d]), 32'd1);
            check($sformatf("d%0d_rst_done", d),  32'(done_v[d]),  32'd0);
            check($sformatf("d%0d_rst_match", d), 32'(match_v[d]), 32'd0);
            check($sformatf("d%0d_rst_meets", d), 32'(meets_v[d]), 32'd0);
            check($sformatf("d%0d_rst_hash", d),  32'(hc_v[d]),    32'd0);
        end

        for (int d = 0; d < 3; d++) begin
            for (int v = 0; v < 8; v++) begin
                if (v == 5) begin
                    tries = 0;
                    do begin
                        p = {$urandom, $urandom, $urandom}; n = $urandom;
                        exp_h = model_hash(p, n); tries++;
                    end while (exp_h[23:16] != 8'hFF && exp_h[15:8] != 8'hFF && tries < 5000);
                end else if (v % 2 == 0) begin
                    p = {$urandom, $urandom, $urandom}; n = $urandom;
                end
                exp_h = model_hash(p, n);
                mx = (exp_h[23:16] > exp_h[15:8]) ? exp_h[23:16] : exp_h[15:8];
                case (v)
                    0, 1:    tgt = 8'h10;
                    2:       tgt = 8'h00;
                    3, 5:    tgt = 8'hFF;
                    4:       tgt = 8'($urandom);
                    6:       tgt = mx;
                    default: tgt = (mx == 8'hFF) ? 8'hFF : mx + 8'd1;
                endcase
                hin = (v == 1 || v == 4) ? (exp_h ^ 24'h1) : exp_h;
                run_one(d, p, n, tgt, hin);
                check($sformatf("d%0d_v%0d_latency", d, v), 32'(got_lat), 32'(32 / (1 << d) + 2));
                check($sformatf("d%0d_v%0d_hash", d, v),  32'(got_hash),  32'(exp_h));
                check($sformatf("d%0d_v%0d_match", d, v), 32'(got_match), 32'(hin == exp_h));
                check($sformatf("d%0d_v%0d_meets", d, v), 32'(got_meets), 32'(model_meets(exp_h, tgt)));
                check($sformatf("d%0d_v%0d_ready_done", d, v), 32'(got_ready), 32'd1);
                check($sformatf("d%0d_v%0d_pulse", d, v), 32'(got_done_after), 32'd0);
            end
        end

        // Starts while busy must be ignored.
        p = {$urandom, $urandom, $urandom}; n = $urandom; exp_h = model_hash(p, n);
        @(negedge clk);
        payload = p; nonce = n; target = 8'h10; hash_in = exp_h; start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        dones = 0; got_lat = -1;
        for (int e = 1; e <= 45; e++) begin
            @(posedge clk); #1;
            if (done_v[0]) begin
                dones++;
                if (got_lat < 0) got_lat = e;
            end
            start_v[0] = (e == 5 || e == 20);
        end
        start_v[0] = 1'b0;
        check("busy_dones", 32'(dones), 32'd1);
        check("busy_latency", 32'(got_lat), 32'd34);
        check("busy_hash", 32'(hc_v[0]), 32'(exp_h));

        // Back-to-back start in the DONE cycle.
        p2 = {$urandom, $urandom, $urandom}; n2 = $urandom;
        @(negedge clk);
        payload = p; nonce = n; target = 8'h10; hash_in = exp_h; start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        wait_done(0, got_lat);
        check("b2b_first_latency", 32'(got_lat), 32'd34);
        payload = p2; nonce = n2; target = 8'hFF; hash_in = model_hash(p2, n2);
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        wait_done(0, lat2);
        check("b2b_second_latency", 32'(lat2), 32'd34);
        check("b2b_second_hash", 32'(hc_v[0]), 32'(model_hash(p2, n2)));
        check("b2b_second_match", 32'(match_v[0]), 32'd1);

        // Reset in the middle of a check.
        @(negedge clk);
        payload = p; nonce = n; target = 8'hFF; hash_in = exp_h; start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        repeat (11) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midrst_ready", 32'(ready_v[0]), 32'd1);
        check("midrst_hash",  32'(hc_v[0]),    32'd0);
        check("midrst_match", 32'(match_v[0]), 32'd0);
        check("midrst_meets", 32'(meets_v[0]), 32'd0);
        dones = 0;
        for (int e = 0; e < 40; e++) begin
            @(posedge clk); #1;
            if (done_v[0]) dones++;
        end
        check("midrst_no_done", 32'(dones), 32'd0);
        run_one(0, p, n, 8'h10, exp_h);
        check("midrst_after_latency", 32'(got_lat), 32'd34);
        check("midrst_after_hash", 32'(got_hash), 32'(exp_h));
        check("midrst_after_match", 32'(got_match), 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/micro_hash_verify.md
Name: micro_hash_verify

Overview:
- Receiving-end checker for the micro-hash miner.
- Takes a reported solution (payload, nonce, target, hash) and recomputes the 24-bit micro-hash iteratively.
- Flags whether the recomputed hash equals the reported one and whether it meets the target.
- Sits downstream of the miner's terminado/nonceOut/hashOut outputs; used as an on-chip result validator and as a formal/sim checker.

Parameters:
- UNROLL, 1, hash rounds per clock. Legal values are 1, 2 and 4; any other value is a compile-time error.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request check; sampled only when ready=1.
- payload  in  96  block payload; payload[95:88] is byte W0.
- nonce  in  32  candidate nonce; nonce[31:24] is byte W12.
- target  in  8  difficulty target.
- hash_in  in  24  reported hash; [23:16]=H0, [15:8]=H1, [7:0]=H2.
- ready  out  1  block idle/done, start accepted this cycle.
- done  out  1  one-cycle pulse, results valid.
- match  out  1  hash_calc == captured hash_in.
- meets  out  1  hash_calc[23:16] < target and hash_calc[15:8] < target.
- hash_calc  out  24  recomputed hash, same packing as hash_in.

Behaviour:
- Reset (clk edge with reset=1), regardless of state: state=IDLE, ready=1, done=0, match=0, meets=0, hash_calc=0, round counter=0. A reset mid-operation aborts the check with no done pulse.
- States:
  - IDLE: ready=1. start=1 captures payload, nonce, target and hash_in into registers, loads W0..W15 into the 16-byte window, sets a,b,c = 0x01,0x89,0xFE and i=0, then goes to ROUND.
  - ROUND: ready=0. UNROLL rounds per cycle; i += UNROLL. After i reaches 32, go to FINAL.
  - FINAL: ready=0. Computes hash_calc = {0x01+a, 0x89+b, 0xFE+c}, each byte modulo 256. Registers match and meets, then goes to DONE.
  - DONE: done=1 and ready=1 for exactly one cycle; outputs are held. start=1 here is accepted (back-to-back, next state ROUND); otherwise next state is IDLE.
- Round i (team micro-hash definition):
  - If i ≤ 16: k=0x99, x=a^b. Otherwise k=0xA1, x=a^b^c.
  - Update a'=b^c, b'=c<<4 (8-bit, truncated), c'=x+k+W[i] (mod 256).
- Schedule: for i ≥ 16, W[i] = W[i-3] | (W[i-9] ^ W[i-14]). Generated on the fly from the 16-byte sliding window, which shifts by one byte per round. No 32-entry array.
- Latency: done is high in the cycle starting (32/UNROLL + 2) edges after the accepting edge. That is 34 for UNROLL=1, 18 for UNROLL=2, 10 for UNROLL=4.
- start while ready=0 is ignored, not queued. Input changes after capture do not affect the result.
- match, meets and hash_calc hold their values until the next FINAL or reset.
- Boundaries:
  - target=0x00 → meets=0 always.
  - target=0xFF → meets=0 only if H0=0xFF or H1=0xFF.
  - The comparison is strict less-than, unsigned.

Decomposition:
- Shared package micro_hash_pkg holds:
  - H_INIT bytes {0x01,0x89,0xFE};
  - K_LO=0x99, K_HI=0xA1, ROUNDS=32, SPLIT_ROUND=16;
  - the state encoding (IDLE, ROUND, FINAL, DONE).
- Sub-module micro_hash_round: combinational single round. Inputs a, b, c, w, round index; outputs a', b', c'. Instantiated UNROLL times in a chain. The miner reuses the same sub-module.

Test Plan:
- Reset: hold reset for 3 cycles → ready=1, done=0, match=0, meets=0, hash_calc=0.
- Golden check: random payload/nonce, hash_in = reference-model hash, target=0x10, UNROLL=1 → done exactly 34 cycles after the start edge; match=1; meets equals the model's result; hash_calc equals the model's hash.
- Corrupted hash: same vector with hash_in[0] flipped → match=0, hash_calc unchanged. target=0x00 → meets=0.
- Handshake: pulse start again at cycles 5 and 20 while busy → ignored, exactly one done. start in the DONE cycle → a second done 34 cycles later.
- Reset mid-operation: assert reset at round 10 → no done pulse, outputs zeroed; a new start then completes normally.
- Unroll: repeat the golden check with UNROLL=2 and 4 → identical hash_calc; latency 18 and 10 cycles.
